conv3x3_param: RTL and testbench

CONV3X3_PARAM -- requirements
Module: conv3x3_param

---
 rtl/conv3x3_param_pkg.sv | 21 ++
 rtl/conv3x3_param_line_buffer.sv | 22 ++
 rtl/conv3x3_param.sv | 130 +++++++++++++
 tb/tb_conv3x3_param.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv3x3_param_pkg.sv
// conv3x3_param_pkg: shared mode encodings, default Sobel-X kernel and accumulator sizing
// for the 3x3 convolution filter.
package conv3x3_param_pkg;

    typedef enum logic [1:0] {
        MODE_ABS     = 2'b00,
        MODE_CLAMP   = 2'b01,
        MODE_RAW     = 2'b10,
        MODE_ABS_ALT = 2'b11
    } mode_e;

    localparam int KTAPS = 9;

    // Row-major, entry 0 multiplies the leftmost pixel of the oldest line.
    localparam int SOBEL_X [KTAPS] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};

    function automatic int acc_width(input int pw, input int cw);
        return pw + cw + 5;
    endfunction

endpackage

// File: rtl/conv3x3_param_line_buffer.sv
// line_buffer: one image line of pixels, indexed by column; read is combinational so the
// old contents at a column are seen in the same cycle they are overwritten.
module line_buffer #(
    parameter int W  = 220,
    parameter int PW = 8
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic [$clog2(W)-1:0] addr,
    input  logic [PW-1:0]        din,
    output logic [PW-1:0]        dout
);

    logic [PW-1:0] mem [W];

    always_ff @(posedge clk) begin
        if (en) mem[addr] <= din;
    end

    assign dout = mem[addr];

endmodule

// File: rtl/conv3x3_param.sv
// conv3x3_param: streaming 3x3 convolution over a raster image with a shadow/active
// coefficient bank, a two-stage MAC/post-process pipeline and frame-end marking.
module conv3x3_param
    import conv3x3_param_pkg::*;
#(
    parameter int W  = 220,
    parameter int H  = 220,
    parameter int PW = 8,
    parameter int CW = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PW-1:0]        pxl_in,
    input  logic                 pxl_valid,
    input  logic                 sof,
    input  logic [1:0]           mode,
    input  logic                 coef_we,
    input  logic [3:0]           coef_addr,
    input  logic signed [CW-1:0] coef_data,
    output logic [PW-1:0]        pxl_out,
    output logic                 out_valid,
    output logic                 out_eof
);

    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);
    localparam int AW = acc_width(PW, CW);

    logic [XW-1:0]        col_q, col_d, eff_col;
    logic [YW-1:0]        row_q, row_d, eff_row;
    logic                 busy_q, busy_d;
    logic [PW-1:0]        win_q [KTAPS];
    logic [PW-1:0]        win_d [KTAPS];
    logic [PW-1:0]        col_in [3];
    logic signed [CW-1:0] shadow_q [KTAPS];
    logic signed [CW-1:0] shadow_d [KTAPS];
    logic signed [CW-1:0] active_q [KTAPS];
    logic signed [CW-1:0] active_d [KTAPS];
    logic                 v0_q, v0_d, e0_q, e0_d, v1_q, e1_q;
    logic signed [AW-1:0] sum_q, sum_d;
    logic [AW-1:0]        mag;
    logic [PW-1:0]        sat, post;
    logic [PW-1:0]        pxl_out_q, pxl_out_d;
    logic                 out_valid_q, out_eof_q;
    logic [PW-1:0]        lb0_out, lb1_out;
    logic                 sof_a, last_col, last_pix, commit;
    mode_e                md;

    // lb0 holds the previous line, lb1 the line before it.
    line_buffer #(.W(W), .PW(PW)) u_lb0 (
        .clk(clk), .en(pxl_valid), .addr(eff_col), .din(pxl_in), .dout(lb0_out)
    );
    line_buffer #(.W(W), .PW(PW)) u_lb1 (
        .clk(clk), .en(pxl_valid), .addr(eff_col), .din(lb0_out), .dout(lb1_out)
    );

    always_comb begin
        sof_a    = pxl_valid && sof;
        eff_col  = sof_a ? '0 : col_q;
        eff_row  = sof_a ? '0 : row_q;
        last_col = eff_col == XW'(W - 1);
        last_pix = last_col && eff_row == YW'(H - 1);
        col_d    = !pxl_valid ? col_q : last_col ? '0 : eff_col + 1'b1;
        row_d    = !pxl_valid ? row_q : !last_col ? eff_row : last_pix ? '0 : eff_row + 1'b1;
        busy_d   = pxl_valid ? !last_pix : busy_q;
        commit   = sof_a || !busy_q;
        v0_d     = pxl_valid && eff_row >= YW'(2) && eff_col >= XW'(2);
        e0_d     = pxl_valid && last_pix;
        col_in[0] = lb1_out;
        col_in[1] = lb0_out;
        col_in[2] = pxl_in;
        for (int r = 0; r < 3; r++) begin
            win_d[3*r]   = pxl_valid ? win_q[3*r+1] : win_q[3*r];
            win_d[3*r+1] = pxl_valid ? win_q[3*r+2] : win_q[3*r+1];
            win_d[3*r+2] = pxl_valid ? col_in[r]    : win_q[3*r+2];
        end
        sum_d = '0;
        for (int k = 0; k < KTAPS; k++) begin
            shadow_d[k] = (coef_we && coef_addr == 4'(k)) ? coef_data : shadow_q[k];
            active_d[k] = commit ? shadow_d[k] : active_q[k];
            sum_d = sum_d + AW'($signed({1'b0, win_q[k]})) * AW'(active_q[k]);
        end
        md        = mode_e'(mode);
        mag       = sum_q[AW-1] ? -sum_q : sum_q;
        sat       = mag > AW'({PW{1'b1}}) ? '1 : mag[PW-1:0];
        post      = md == MODE_RAW ? sum_q[PW-1:0] : (md == MODE_CLAMP && sum_q[AW-1]) ? '0 : sat;
        pxl_out_d = v1_q ? post : pxl_out_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_q       <= '0;
            row_q       <= '0;
            busy_q      <= 1'b0;
            v0_q        <= 1'b0;
            e0_q        <= 1'b0;
            v1_q        <= 1'b0;
            e1_q        <= 1'b0;
            sum_q       <= '0;
            pxl_out_q   <= '0;
            out_valid_q <= 1'b0;
            out_eof_q   <= 1'b0;
            for (int k = 0; k < KTAPS; k++) begin
                win_q[k]    <= '0;
                shadow_q[k] <= CW'(SOBEL_X[k]);
                active_q[k] <= CW'(SOBEL_X[k]);
            end
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            busy_q      <= busy_d;
            win_q       <= win_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            v0_q        <= v0_d;
            e0_q        <= e0_d;
            sum_q       <= sum_d;
            v1_q        <= v0_q;
            e1_q        <= e0_q;
            pxl_out_q   <= pxl_out_d;
            out_valid_q <= v1_q;
            out_eof_q   <= e1_q;
        end
    end

    assign pxl_out   = pxl_out_q;
    assign out_valid = out_valid_q;
    assign out_eof   = out_eof_q;

endmodule

// File: tb/tb_conv3x3_param.sv
// tb_conv3x3_param: table vectors plus randomized frames checked against an image-level
// convolution model and a latency-tagged scoreboard.
module tb_conv3x3_param;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int PW = 8;
    localparam int CW = 5;
    localparam int NOUT = (W - 2) * (H - 2);

    logic                 clk = 1'b0;
    logic                 reset;
    logic [PW-1:0]        pxl_in;
    logic                 pxl_valid, sof, coef_we;
    logic [1:0]           mode;
    logic [3:0]           coef_addr;
    logic signed [CW-1:0] coef_data;
    logic [PW-1:0]        pxl_out;
    logic                 out_valid, out_eof;

    conv3x3_param #(.W(W), .H(H), .PW(PW), .CW(CW)) dut (
        .clk(clk), .reset(reset), .pxl_in(pxl_in), .pxl_valid(pxl_valid), .sof(sof),
        .mode(mode), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .pxl_out(pxl_out), .out_valid(out_valid), .out_eof(out_eof)
    );

    always #5 clk = ~clk;

    typedef struct {
        int val;
        int eof;
        int due;
    } exp_t;

    typedef struct {
        int pix;
        int kern;
        int md;
        int exp;
    } vec_t;

    int   n_tests = 0, n_fail = 0, cyc = 0;
    int   img [H][W];
    int   sobel [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    int   m_shadow [9], m_active [9], mid_k [9], k9 [9];
    bit   m_busy;
    exp_t q [$];
    int   out_cnt, eof_cnt, out_min, out_max;
    int   out_log [$], ref_log [$];
    vec_t vecs [12];

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int post_model(input int s, input int md);
        int a;
        a = s < 0 ? -s : s;
        if (md == 2) return s & 255;
        if (md == 1 && s < 0) return 0;
        return a > 255 ? 255 : a;
    endfunction

    function automatic int exp_at(input int r, input int c);
        int s;
        s = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                s += m_active[i*3+j] * img[r-2+i][c-2+j];
        return post_model(s, int'(mode));
    endfunction

    // Scoreboard: every output must match the oldest expectation and arrive on its due cycle.
    always @(negedge clk) begin
        if (reset) begin
            if (out_valid) begin
                exp_t e;
                out_cnt++;
                if (out_eof) eof_cnt++;
                out_log.push_back(int'(pxl_out));
                if (int'(pxl_out) < out_min) out_min = int'(pxl_out);
                if (int'(pxl_out) > out_max) out_max = int'(pxl_out);
                if (q.size() == 0) chk("unexpected out_valid", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("pxl_out", int'(pxl_out), e.val);
                    chk("out_eof", int'(out_eof), e.eof);
                    chk("latency cycle", cyc, e.due);
                end
            end else begin
                if (out_eof) chk("out_eof without out_valid", 1, 0);
                if (q.size() > 0 && cyc > q[0].due) begin
                    chk("missing output", 0, 1);
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic write_coefs(input int k [9]);
        for (int i = 0; i < 9; i++) begin
            coef_we = 1'b1; coef_addr = 4'(i); coef_data = CW'(k[i]);
            m_shadow[i] = k[i];
            if (!m_busy) m_active = m_shadow;
            @(negedge clk);
        end
        coef_we = 1'b1; coef_addr = 4'd12; coef_data = 5'sd3;
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic drive_frame(input int gap_pct, input bit wr_mid, input int sof_addr,
                               input int sof_data, input int stop_at);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                pxl_valid = 1'b0; sof = 1'b0; coef_we = 1'b0;
                if (r * W + c == stop_at) return;
                if (wr_mid && r == 3 && c == 0) write_coefs(mid_k);
                while ($urandom_range(99) < gap_pct) @(negedge clk);
                if (r == 0 && c == 0) begin
                    if (sof_addr >= 0) begin
                        m_shadow[sof_addr] = sof_data;
                        coef_we = 1'b1; coef_addr = 4'(sof_addr); coef_data = CW'(sof_data);
                    end
                    m_active = m_shadow;
                    m_busy = 1'b1;
                end
                pxl_valid = 1'b1; sof = (r == 0 && c == 0); pxl_in = PW'(img[r][c]);
                if (r >= 2 && c >= 2) q.push_back('{exp_at(r, c), int'(r == H-1 && c == W-1), cyc + 3});
                if (r == H-1 && c == W-1) m_busy = 1'b0;
                @(negedge clk);
            end
        end
        pxl_valid = 1'b0; sof = 1'b0; coef_we = 1'b0;
    endtask

    task automatic run_frame(input string nm, input int gap_pct, input bit wr_mid,
                             input int sof_addr, input int sof_data);
        out_cnt = 0; eof_cnt = 0; out_min = 1 << 30; out_max = -1; out_log.delete();
        drive_frame(gap_pct, wr_mid, sof_addr, sof_data, -1);
        for (int i = 0; i < 12 && q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        chk({nm, " drain"}, q.size(), 0);
        chk({nm, " output count"}, out_cnt, NOUT);
        chk({nm, " eof count"}, eof_cnt, 1);
    endtask

    task automatic fill_const(input int v);
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = v;
    endtask

    task automatic fill_rand();
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = int'($urandom_range(255));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // {pixel, kernel (99 = Sobel-X, else all taps), mode, expected output}
        vecs[0]  = '{100, 99, 0, 0};
        vecs[1]  = '{255,  1, 0, 255};
        vecs[2]  = '{255,  1, 2, 247};
        vecs[3]  = '{255, -1, 0, 255};
        vecs[4]  = '{255, -1, 1, 0};
        vecs[5]  = '{ 20,  1, 1, 180};
        vecs[6]  = '{ 20, -1, 2, 76};
        vecs[7]  = '{ 10, -1, 3, 90};
        vecs[8]  = '{ 28,  1, 0, 252};
        vecs[9]  = '{ 29,  1, 0, 255};
        vecs[10] = '{255, 15, 2, 121};
        vecs[11] = '{255,-16, 2, 144};

        reset = 1'b0; pxl_valid = 1'b0; sof = 1'b0; pxl_in = '0; mode = 2'd0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        m_shadow = sobel; m_active = sobel; m_busy = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset out_eof", int'(out_eof), 0);
        chk("reset pxl_out", int'(pxl_out), 0);
        reset = 1'b1;
        @(negedge clk);

        fill_const(100);
        run_frame("const100", 0, 1'b0, -1, 0);
        chk("const100 min", out_min, 0);
        chk("const100 max", out_max, 0);

        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = c * 10;
        run_frame("ramp", 0, 1'b0, -1, 0);
        chk("ramp min", out_min, 80);
        chk("ramp max", out_max, 80);

        foreach (vecs[i]) begin
            for (int k = 0; k < 9; k++) k9[k] = vecs[i].kern == 99 ? sobel[k] : vecs[i].kern;
            write_coefs(k9);
            mode = 2'(vecs[i].md);
            fill_const(vecs[i].pix);
            run_frame($sformatf("vec%0d", i), 0, 1'b0, -1, 0);
            chk($sformatf("vec%0d min", i), out_min, vecs[i].exp);
            chk($sformatf("vec%0d max", i), out_max, vecs[i].exp);
        end

        // Same random image and kernel with and without input gaps.
        for (int k = 0; k < 9; k++) k9[k] = int'($urandom_range(31)) - 16;
        write_coefs(k9);
        mode = 2'd2;
        fill_rand();
        run_frame("nogap", 0, 1'b0, -1, 0);
        ref_log = out_log;
        run_frame("gap50", 50, 1'b0, -1, 0);
        chk("gap run length", out_log.size(), ref_log.size());
        for (int i = 0; i < out_log.size() && i < ref_log.size(); i++)
            chk($sformatf("gap run output %0d", i), out_log[i], ref_log[i]);
        mode = 2'd1;
        fill_rand();
        run_frame("rand clamp", 30, 1'b0, -1, 0);

        // Mid-frame coefficient write only takes effect at the next sof.
        write_coefs(sobel);
        mode = 2'd0;
        for (int k = 0; k < 9; k++) mid_k[k] = k == 4 ? 8 : -1;
        fill_rand();
        run_frame("midwrite", 20, 1'b1, -1, 0);
        fill_rand();
        run_frame("newkernel", 0, 1'b0, -1, 0);
        fill_const(50);
        run_frame("newkernel const", 0, 1'b0, -1, 0);
        chk("newkernel const value", out_max, 0);

        // Write coincident with the committing sof pixel.
        fill_rand();
        run_frame("sofwrite", 0, 1'b0, 4, 5);

        // Asynchronous reset in the middle of a frame.
        fill_rand();
        drive_frame(0, 1'b0, -1, 0, 3 * W + 4);
        #1;
        q.delete();
        reset = 1'b0;
        #1;
        chk("midreset out_valid", int'(out_valid), 0);
        chk("midreset out_eof", int'(out_eof), 0);
        chk("midreset pxl_out", int'(pxl_out), 0);
        @(negedge clk);
        reset = 1'b1;
        m_shadow = sobel; m_active = sobel; m_busy = 1'b0;
        mode = 2'd0;
        fill_rand();
        run_frame("after reset", 0, 1'b0, -1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
